deser_1to8: RTL and testbench

- Serial-to-parallel collector: the receive-side counterpart of the team's 8:1 bit-select mux.
- Each accepted serial bit is steered into bit position idx of an accumulation register by a 1:8 demux. idx is a 3-bit counter that steps 0..7, the same select order the mux uses.
- When the 8th bit is accepted, the byte is handed to a valid/ready output register.
- Sits at the sink end of any serialised byte path built from the 8:1 mux plus a select counter.

---
 rtl/deser_pkg.sv | 22 ++
 rtl/demux_1to8.sv | 16 +
 rtl/deser_1to8.sv | 102 ++++++++++
 tb/tb_deser_1to8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants and helpers for the 1:8 deserialiser slice.
// DESER_PARITY_EN adds a trailing even-parity slot to every frame.
package deser_pkg;

  localparam int unsigned DESER_WIDTH_DEF = 8;

  // Serial slots per frame, including the parity slot when enabled.
`ifdef DESER_PARITY_EN
  localparam int unsigned DESER_FRAME_LEN = DESER_WIDTH_DEF + 1;
`else
  localparam int unsigned DESER_FRAME_LEN = DESER_WIDTH_DEF;
`endif

  function automatic int unsigned deser_idx_w(input int unsigned width);
`ifdef DESER_PARITY_EN
    return $clog2(width) + 1;
`else
    return $clog2(width);
`endif
  endfunction

endpackage

// File: rtl/demux_1to8.sv
// 1:N demux: decodes sel into a one-hot write enable, all-zero when en is low.
module demux_1to8 import deser_pkg::*; #(
  parameter int unsigned N     = DESER_WIDTH_DEF,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     we
);

  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/deser_1to8.sv
// Serial-to-parallel collector with a valid/ready output register.
// DESER_PARITY_EN appends an even-parity slot and an out_perr flag.
module deser_1to8 import deser_pkg::*; #(
  parameter int unsigned WIDTH = DESER_WIDTH_DEF,
  parameter int unsigned IDX_W = deser_idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             d,
  output logic [IDX_W-1:0] idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DESER_PARITY_EN
  ,
  output logic             out_perr
`endif
);

  localparam int unsigned SEL_W = $clog2(WIDTH);
`ifdef DESER_PARITY_EN
  localparam int unsigned SLOTS = WIDTH + 1;
`else
  localparam int unsigned SLOTS = WIDTH;
`endif
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLOTS - 1);

  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] acc_q, acc_d, we, frame_data;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             at_last, accept, complete, consume, wr_en;

  assign at_last  = (idx_q == LAST);
  // Only the completing slot waits on the output register.
  assign in_ready = !(at_last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready && !clear;
  assign complete = accept && at_last;
  assign consume  = out_valid_q && out_ready;

`ifdef DESER_PARITY_EN
  assign wr_en      = accept && !at_last;
  assign frame_data = acc_q;
`else
  assign wr_en      = accept;
  assign frame_data = {d, acc_q[WIDTH-2:0]};
`endif

  demux_1to8 #(
    .N     (WIDTH),
    .SEL_W (SEL_W)
  ) u_demux (
    .sel (idx_q[SEL_W-1:0]),
    .en  (wr_en),
    .we  (we)
  );

  assign acc_d = (acc_q & ~we) | (we & {WIDTH{d}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (accept) idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
      if (complete) begin
        out_valid_q <= 1'b1;
        out_data_q  <= frame_data;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic out_perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_perr_q <= 1'b0;
    end else if (complete) begin
      out_perr_q <= (^acc_q) ^ d;
    end
  end

  assign out_perr = out_perr_q;
`endif

  assign idx       = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_deser_1to8.sv
// Directed bench for deser_1to8 with a scoreboard of expected frames.
// DESER_PARITY_EN adds the parity slot to every frame and checks out_perr.
module tb_deser_1to8;
  import deser_pkg::*;

  localparam int unsigned W    = DESER_WIDTH_DEF;
  localparam int unsigned IW   = deser_idx_w(W);
  localparam int          LAST = int'(DESER_FRAME_LEN) - 1;

  logic          clk, rst_n, clear, in_valid, in_ready, d, out_valid, out_ready;
  logic [IW-1:0] idx;
  logic [W-1:0]  out_data;
`ifdef DESER_PARITY_EN
  logic          out_perr;
`endif

  int          n_cmp, n_err;
  int          m_idx;
  logic        m_ov;
  logic [8:0]  exp_q[$];

  deser_1to8 #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .idx       (idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DESER_PARITY_EN
    ,
    .out_perr  (out_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Frame word: bit 8 is the parity slot (even parity) when enabled.
  function automatic logic [8:0] fr(input logic [7:0] b);
`ifdef DESER_PARITY_EN
    return {^b, b};
`else
    return {1'b0, b};
`endif
  endfunction

  // One clock: drive, check against the cycle model, clock, advance the model.
  task automatic step(input logic v, input logic bd, input logic ordy, input logic clr,
                      output logic done, output logic accepted);
    logic m_rdy;
    in_valid  = v;
    d         = bd;
    out_ready = ordy;
    clear     = clr;
    #1;
    m_rdy = !(m_idx == LAST && m_ov && !ordy);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("idx", 32'(idx), 32'(m_idx));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov && exp_q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0][7:0]));
`ifdef DESER_PARITY_EN
      chk("out_perr", 32'(out_perr), 32'(^exp_q[0]));
`endif
    end
    accepted = v && m_rdy && !clr;
    done     = 1'b0;
    @(posedge clk);
    #1;
    if (clr) begin
      if (m_ov && exp_q.size() > 0) void'(exp_q.pop_front());
      m_ov  = 1'b0;
      m_idx = 0;
    end else begin
      if (m_ov && ordy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_ov = 1'b0;
      end
      if (accepted) begin
        if (m_idx == LAST) begin
          m_idx = 0;
          m_ov  = 1'b1;
          done  = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic send_slots(input logic [8:0] bits, input int lo, input int hi,
                            input logic ordy);
    logic done, accepted;
    int   tries;
    for (int i = lo; i <= hi; i++) begin
      tries    = 0;
      accepted = 1'b0;
      while (!accepted) begin
        step(1'b1, bits[i], ordy, 1'b0, done, accepted);
        if (done) exp_q.push_back(bits);
        if (!accepted) begin
          tries++;
          if (tries > 20) begin
            chk("accept_timeout", 32'(accepted), 32'd1);
            return;
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       done, acc;
    logic [8:0] f;
    n_cmp = 0; n_err = 0; m_idx = 0; m_ov = 1'b0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; d = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DESER_PARITY_EN
    chk("rst_out_perr", 32'(out_perr), 32'd0);
`endif

    // Bits 1,0,1,1,0,0,1,0 LSB first -> 8'h4D.
    send_slots(fr(8'h4D), 0, LAST, 1'b1);
    chk("4d_valid", 32'(out_valid), 32'd1);
    chk("4d_data", 32'(out_data), 32'h4D);
    chk("4d_idx", 32'(idx), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, done, acc);
    chk("4d_drained", 32'(out_valid), 32'd0);

    // Back-to-back frames with the output stalled.
    send_slots(fr(8'hA5), 0, LAST, 1'b0);
    f = fr(8'h3C);
    send_slots(f, 0, LAST - 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, f[LAST], 1'b0, 1'b0, done, acc);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'hA5);
    end
    send_slots(f, LAST, LAST, 1'b1);
    chk("3c_valid", 32'(out_valid), 32'd1);
    chk("3c_data", 32'(out_data), 32'h3C);

    // Consume 3C on the very cycle the next frame completes.
    f = fr(8'h96);
    send_slots(f, 0, LAST - 1, 1'b0);
    send_slots(f, LAST, LAST, 1'b1);
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_data", 32'(out_data), 32'h96);

    // Clear at idx 4 flushes the partial frame and output valid, keeps data.
    send_slots(fr(8'h00), 0, 3, 1'b0);
    chk("pre_clear_idx", 32'(idx), 32'd4);
    step(1'b1, 1'b1, 1'b0, 1'b1, done, acc);
    chk("clear_idx", 32'(idx), 32'd0);
    chk("clear_valid", 32'(out_valid), 32'd0);
    chk("clear_data", 32'(out_data), 32'h96);
    send_slots(fr(8'hFF), 0, LAST, 1'b0);
    chk("ff_data", 32'(out_data), 32'hFF);

    // Asynchronous reset mid-frame at idx 5.
    send_slots(fr(8'h00), 0, 4, 1'b0);
    chk("pre_rst_idx", 32'(idx), 32'd5);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_idx = 0;
    m_ov  = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    send_slots(fr(8'h5A), 0, LAST, 1'b1);
    chk("5a_data", 32'(out_data), 32'h5A);
    step(1'b0, 1'b0, 1'b1, 1'b0, done, acc);
    chk("5a_drained", 32'(out_valid), 32'd0);

`ifdef DESER_PARITY_EN
    send_slots({1'b1, 8'h07}, 0, LAST, 1'b1);
    chk("perr_good", 32'(out_perr), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, done, acc);
    send_slots({1'b0, 8'h07}, 0, LAST, 1'b1);
    chk("perr_bad", 32'(out_perr), 32'd1);
    chk("perr_bad_data", 32'(out_data), 32'h07);
    step(1'b0, 1'b0, 1'b1, 1'b0, done, acc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
